// File: rtl/cond_pkg.sv
// Shared encodings for the condition/flags stage: ARM condition codes,
// flag bit positions inside {N,Z,C,V} and the FlagW request bits.
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: condition field plus
// {N,Z,C,V} in, pass/fail out. Kept separate so branch prediction can reuse it.
module cond_check
   import cond_pkg::*;
#(
   parameter bit NEVER_EXEC_NV = 1'b1
) (
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       cond_ex_o
);

   logic n_s;
   logic z_s;
   logic c_s;
   logic v_s;
   logic cond_ex_s;

   assign n_s = flags_i[FLAG_N];
   assign z_s = flags_i[FLAG_Z];
   assign c_s = flags_i[FLAG_C];
   assign v_s = flags_i[FLAG_V];

   // Condition-code decode; the NV slot is configurable as never/always.
   always_comb begin
      cond_ex_s = 1'b0;
      case (cond_i)
         COND_EQ: cond_ex_s = z_s;
         COND_NE: cond_ex_s = ~z_s;
         COND_CS: cond_ex_s = c_s;
         COND_CC: cond_ex_s = ~c_s;
         COND_MI: cond_ex_s = n_s;
         COND_PL: cond_ex_s = ~n_s;
         COND_VS: cond_ex_s = v_s;
         COND_VC: cond_ex_s = ~v_s;
         COND_HI: cond_ex_s = c_s & ~z_s;
         COND_LS: cond_ex_s = ~c_s | z_s;
         COND_GE: cond_ex_s = (n_s == v_s);
         COND_LT: cond_ex_s = (n_s != v_s);
         COND_GT: cond_ex_s = ~z_s & (n_s == v_s);
         COND_LE: cond_ex_s = z_s | (n_s != v_s);
         COND_AL: cond_ex_s = 1'b1;
         COND_NV: cond_ex_s = ~NEVER_EXEC_NV;
         default: cond_ex_s = 1'b0;
      endcase
   end

   assign cond_ex_o = cond_ex_s;

endmodule

// File: rtl/cond_flags_unit.sv
// Execute-stage condition/flags unit: architectural NZCV register, condition
// evaluation against the registered flags, and gating of decoder write strobes.
module cond_flags_unit
   import cond_pkg::*;
#(
   parameter bit NEVER_EXEC_NV = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       NoWrite,
   input  logic       MemW,
   input  logic       Stall,
   input  logic       Flush,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic       Carry,
   output logic [3:0] Flags
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;
   logic       cond_ex_s;
   logic       go_s;

   // Evaluated only from the registered flags, so ALUFlags never reaches an output.
   cond_check #(
      .NEVER_EXEC_NV (NEVER_EXEC_NV)
   ) u_cond_check (
      .cond_i    (Cond),
      .flags_i   (flags_q),
      .cond_ex_o (cond_ex_s)
   );

   assign go_s = cond_ex_s & ~Stall & ~Flush;

   // Next flag value: each half updates independently, only when the instruction goes.
   always_comb begin
      flags_d = flags_q;
      if (go_s) begin
         if (FlagW[FLAGW_NZ]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
         end else begin
            flags_d[FLAG_N] = flags_q[FLAG_N];
            flags_d[FLAG_Z] = flags_q[FLAG_Z];
         end
         if (FlagW[FLAGW_CV]) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
         end else begin
            flags_d[FLAG_C] = flags_q[FLAG_C];
            flags_d[FLAG_V] = flags_q[FLAG_V];
         end
      end else begin
         flags_d = flags_q;
      end
   end

   // Architectural flag register; reset drops any pending update.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign CondEx   = cond_ex_s;
   assign PCSrc    = PCS & go_s;
   assign RegWrite = RegW & ~NoWrite & go_s;
   assign MemWrite = MemW & go_s;
   assign Carry    = flags_q[FLAG_C];
   assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Bench for cond_flags_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural flag/condition model.
module tb_cond_flags_unit;

   logic       CLK;
   logic       RESET;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, NoWrite, MemW, Stall, Flush;

   logic       pcsrc_a, regwrite_a, memwrite_a, condex_a, carry_a;
   logic [3:0] flags_a;
   logic       pcsrc_b, regwrite_b, memwrite_b, condex_b, carry_b;
   logic [3:0] flags_b;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   logic [3:0] m_flags [2];

   cond_flags_unit dut (
      .CLK(CLK), .RESET(RESET), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .NoWrite(NoWrite), .MemW(MemW), .Stall(Stall),
      .Flush(Flush), .PCSrc(pcsrc_a), .RegWrite(regwrite_a), .MemWrite(memwrite_a),
      .CondEx(condex_a), .Carry(carry_a), .Flags(flags_a)
   );

   cond_flags_unit #(.NEVER_EXEC_NV(1'b0)) dut_nv0 (
      .CLK(CLK), .RESET(RESET), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .NoWrite(NoWrite), .MemW(MemW), .Stall(Stall),
      .Flush(Flush), .PCSrc(pcsrc_b), .RegWrite(regwrite_b), .MemWrite(memwrite_b),
      .CondEx(condex_b), .Carry(carry_b), .Flags(flags_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ARM condition semantics: pairs of codes share a base test, odd code inverts it.
   function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f,
                                       input logic never_nv);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return !never_nv;
      return c[0] ? !base : base;
   endfunction

   function automatic logic go_model(input int idx);
      return cond_model(Cond, m_flags[idx], idx == 0) && !Stall && !Flush;
   endfunction

   // Reference flag state: masked merge of ALUFlags when the instruction goes.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_flags[0] <= 4'b0000;
         m_flags[1] <= 4'b0000;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (go_model(i))
               m_flags[i] <= (m_flags[i] & ~{{2{FlagW[1]}}, {2{FlagW[0]}}})
                           | (ALUFlags & {{2{FlagW[1]}}, {2{FlagW[0]}}});
         end
      end
   end

   task automatic check_inst(input int idx, input logic pcsrc, input logic regwrite,
                             input logic memwrite, input logic condex,
                             input logic carry, input logic [3:0] flags);
      logic g;
      g = go_model(idx);
      chk($sformatf("m%0d_condex", idx), {3'b000, condex},
          {3'b000, cond_model(Cond, m_flags[idx], idx == 0)});
      chk($sformatf("m%0d_pcsrc", idx), {3'b000, pcsrc}, {3'b000, PCS && g});
      chk($sformatf("m%0d_regwrite", idx), {3'b000, regwrite}, {3'b000, RegW && !NoWrite && g});
      chk($sformatf("m%0d_memwrite", idx), {3'b000, memwrite}, {3'b000, MemW && g});
      chk($sformatf("m%0d_carry", idx), {3'b000, carry}, {3'b000, m_flags[idx][1]});
      chk($sformatf("m%0d_flags", idx), flags, m_flags[idx]);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         check_inst(0, pcsrc_a, regwrite_a, memwrite_a, condex_a, carry_a, flags_a);
         check_inst(1, pcsrc_b, regwrite_b, memwrite_b, condex_b, carry_b, flags_b);
      end
   end

   task automatic edge1();
      @(posedge CLK);
      #1;
   endtask

   task automatic drv(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                      input logic pcs, input logic regw, input logic nw,
                      input logic memw, input logic st, input logic fl);
      Cond = c; ALUFlags = a; FlagW = fw;
      PCS = pcs; RegW = regw; NoWrite = nw; MemW = memw; Stall = st; Flush = fl;
   endtask

   initial begin
      RESET = 1'b1;
      drv(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      repeat (2) @(posedge CLK);
      #3 RESET = 1'b0;

      // Flag set, then EQ/NE gating of RegWrite
      edge1(); drv(4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0);
      #1 chk("al_condex", {3'b000, condex_a}, 4'h1);
      edge1(); chk("set_flags", flags_a, 4'b0100);
      drv(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
      #1 chk("eq_regwrite", {3'b000, regwrite_a}, 4'h1);
      drv(4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
      #1 chk("ne_regwrite", {3'b000, regwrite_a}, 4'h0);

      // Partial update keeps C,V
      drv(4'hE, 4'b0011, 2'b11, 0, 0, 0, 0, 0, 0);
      edge1(); chk("flags_0011", flags_a, 4'b0011);
      drv(4'hE, 4'b1000, 2'b10, 0, 0, 0, 0, 0, 0);
      edge1(); chk("partial_flags", flags_a, 4'b1011);
      chk("partial_carry", {3'b000, carry_a}, 4'h1);

      // Signed compares with N=1,V=0 then N=1,V=1,Z=0
      drv(4'hE, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0);
      edge1();
      drv(4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0); #1 chk("ge_nv10", {3'b000, condex_a}, 4'h0);
      drv(4'hB, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0); #1 chk("lt_nv10", {3'b000, condex_a}, 4'h1);
      drv(4'hC, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0); #1 chk("gt_nv10", {3'b000, condex_a}, 4'h0);
      drv(4'hD, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0); #1 chk("le_nv10", {3'b000, condex_a}, 4'h1);
      drv(4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0);
      edge1();
      drv(4'hC, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0); #1 chk("gt_nv11", {3'b000, condex_a}, 4'h1);

      // Failed condition writes nothing
      drv(4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0, 0);
      edge1();
      drv(4'h0, 4'b1111, 2'b11, 1, 0, 0, 1, 0, 0);
      #1 chk("fail_pcsrc", {3'b000, pcsrc_a}, 4'h0);
      chk("fail_memwrite", {3'b000, memwrite_a}, 4'h0);
      edge1(); chk("fail_flags", flags_a, 4'b0000);

      // Stall holds the instruction, then it completes
      drv(4'hE, 4'b0010, 2'b11, 1, 1, 0, 1, 1, 0);
      #1 chk("stall_strobes", {1'b0, pcsrc_a, regwrite_a, memwrite_a}, 4'h0);
      chk("stall_condex", {3'b000, condex_a}, 4'h1);
      repeat (3) begin
         edge1(); chk("stall_flags", flags_a, 4'b0000);
      end
      Stall = 1'b0;
      #1 chk("unstall_strobes", {1'b0, pcsrc_a, regwrite_a, memwrite_a}, 4'b0111);
      edge1(); chk("unstall_flags", flags_a, 4'b0010);

      // Flush, alone and with Stall
      drv(4'hE, 4'b0100, 2'b11, 1, 1, 0, 1, 0, 1);
      #1 chk("flush_regwrite", {3'b000, regwrite_a}, 4'h0);
      edge1(); chk("flush_flags", flags_a, 4'b0010);
      Stall = 1'b1;
      edge1(); chk("flush_stall_flags", flags_a, 4'b0010);

      // NV slot under both parameter settings
      drv(4'hF, 4'b1111, 2'b11, 1, 0, 0, 0, 0, 0);
      #1 chk("nv_condex_never", {3'b000, condex_a}, 4'h0);
      chk("nv_condex_always", {3'b000, condex_b}, 4'h1);
      chk("nv_pcsrc_always", {3'b000, pcsrc_b}, 4'h1);
      edge1(); chk("nv_flags_never", flags_a, 4'b0010);
      chk("nv_flags_always", flags_b, 4'b1111);

      // Asynchronous reset mid-cycle with a pending write
      drv(4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0);
      #2 RESET = 1'b1;
      #1 chk("rst_flags", flags_a, 4'h0);
      chk("rst_carry", {3'b000, carry_a}, 4'h0);
      chk("rst_flags_nv0", flags_b, 4'h0);
      Cond = 4'h0; #1 chk("rst_eq", {3'b000, condex_a}, 4'h0);
      Cond = 4'h1; #1 chk("rst_ne", {3'b000, condex_a}, 4'h1);
      Cond = 4'hA; #1 chk("rst_ge", {3'b000, condex_a}, 4'h1);
      RESET = 1'b0;

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         edge1();
         drv(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 63) == 0) begin
            RESET = 1'b1;
            #2 RESET = 1'b0;
         end
      end

      edge1();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
